// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALU function, size and fault encodings for the MIPS control sequencer.
package mips_ctrl_pkg;
   typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_WB, ST_HALT} state_e;
   typedef enum logic [2:0] {CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP} cls_e;
   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] ALU_ADD  = 6'h20;
   localparam logic [5:0] ALU_ADDU = 6'h21;
   localparam logic [5:0] ALU_AND  = 6'h24;
   localparam logic [5:0] ALU_OR   = 6'h25;
   localparam logic [5:0] ALU_XOR  = 6'h26;
   localparam logic [5:0] ALU_SLT  = 6'h2A;
   localparam logic [5:0] ALU_BEQ  = 6'h3C;
   localparam logic [5:0] ALU_BNE  = 6'h3D;
   localparam logic [5:0] ALU_J    = 6'h3E;
   localparam logic [5:0] ALU_LUI  = 6'h3F;
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
   typedef struct packed {
      cls_e       cls;
      logic [5:0] alu_func;
      logic [1:0] size;
      logic       dest_rd;
      logic       b_imm;
      logic       wb_mem;
      logic       illegal;
   } dec_t;
endpackage

// File: rtl/mips_decode.sv
// mips_decode: combinational opcode/func decoder producing instruction class, ALU function, size and selects.
module mips_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] func_i,
   output dec_t       dec_o
);
   always_comb begin
      dec_o = '{cls: CL_IMM, alu_func: func_i, size: SZ_WORD, dest_rd: 1'b0, b_imm: 1'b1, wb_mem: 1'b0, illegal: 1'b0};
      case (opcode_i)
         OP_R:     begin dec_o.cls = CL_R; dec_o.dest_rd = 1'b1; dec_o.b_imm = 1'b0; end
         OP_ADDI:  dec_o.alu_func = ALU_ADD;
         OP_ADDIU: dec_o.alu_func = ALU_ADDU;
         OP_SLTI:  dec_o.alu_func = ALU_SLT;
         OP_ANDI:  dec_o.alu_func = ALU_AND;
         OP_ORI:   dec_o.alu_func = ALU_OR;
         OP_XORI:  dec_o.alu_func = ALU_XOR;
         OP_LUI:   dec_o.alu_func = ALU_LUI;
         OP_LW:    begin dec_o.cls = CL_LOAD; dec_o.alu_func = ALU_ADDU; dec_o.wb_mem = 1'b1; end
         OP_LH:    begin dec_o.cls = CL_LOAD; dec_o.alu_func = ALU_ADDU; dec_o.wb_mem = 1'b1; dec_o.size = SZ_HALF; end
         OP_LB:    begin dec_o.cls = CL_LOAD; dec_o.alu_func = ALU_ADDU; dec_o.wb_mem = 1'b1; dec_o.size = SZ_BYTE; end
         OP_SW:    begin dec_o.cls = CL_STORE; dec_o.alu_func = ALU_ADDU; end
         OP_SH:    begin dec_o.cls = CL_STORE; dec_o.alu_func = ALU_ADDU; dec_o.size = SZ_HALF; end
         OP_SB:    begin dec_o.cls = CL_STORE; dec_o.alu_func = ALU_ADDU; dec_o.size = SZ_BYTE; end
         OP_BEQ:   begin dec_o.cls = CL_BRANCH; dec_o.alu_func = ALU_BEQ; dec_o.b_imm = 1'b0; end
         OP_BNE:   begin dec_o.cls = CL_BRANCH; dec_o.alu_func = ALU_BNE; dec_o.b_imm = 1'b0; end
         OP_J:     begin dec_o.cls = CL_JUMP; dec_o.alu_func = ALU_J; dec_o.b_imm = 1'b0; end
         default:  dec_o.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multi-cycle FETCH/EXEC/MEM/WB sequencer driving the datapath controls.
module mips_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run_in,
   input  logic [5:0] inst_mem_opcode_in,
   input  logic [5:0] inst_mem_func_in,
   input  logic       alu_branch_in,
   input  logic       alu_jump_in,
   input  logic       mem_ready_in,
   output logic       pc_en_out,
   output logic       inst_mux_sel_out,
   output logic       regfile_we_out,
   output logic       alu_mux_sel_out,
   output logic       data_mem_mux_sel_out,
   output logic [5:0] alu_func_out,
   output logic       data_mem_re_out,
   output logic       data_mem_we_out,
   output logic [1:0] data_mem_size_out,
   output logic       branch_taken_out,
   output logic       halted_out,
   output logic [1:0] fault_out
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   state_e        state_q;
   logic [5:0]    op_q, func_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    fault_q;
   dec_t          dec;
   // In FETCH the decoder looks at the live ROM word so an illegal opcode is caught before latching.
   mips_decode u_decode (
      .opcode_i (state_q == ST_FETCH ? inst_mem_opcode_in : op_q),
      .func_i   (state_q == ST_FETCH ? inst_mem_func_in : func_q),
      .dec_o    (dec)
   );
   wire is_ctl   = dec.cls == CL_BRANCH || dec.cls == CL_JUMP;
   wire is_load  = dec.cls == CL_LOAD;
   wire is_store = dec.cls == CL_STORE;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
         op_q    <= '0;
         func_q  <= '0;
         cnt_q   <= '0;
         fault_q <= FAULT_NONE;
      end else begin
         case (state_q)
            ST_FETCH: if (run_in) begin
               op_q    <= inst_mem_opcode_in;
               func_q  <= inst_mem_func_in;
               state_q <= dec.illegal ? ST_HALT : ST_EXEC;
               fault_q <= dec.illegal ? FAULT_ILLEGAL : FAULT_NONE;
            end
            ST_EXEC: begin
               cnt_q   <= '0;
               state_q <= is_ctl ? ST_FETCH : (is_load || is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: if (mem_ready_in) begin
               state_q <= is_load ? ST_WB : ST_FETCH;
            end else begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                  state_q <= ST_HALT;
                  fault_q <= FAULT_TIMEOUT;
               end
            end
            ST_WB:   state_q <= ST_FETCH;
            default: state_q <= ST_HALT;
         endcase
      end
   end
   // Reset gates every output combinationally so a reset mid-MEM/WB never leaks a strobe.
   wire act     = !reset;
   wire in_exec = act && state_q == ST_EXEC;
   wire in_mem  = act && state_q == ST_MEM;
   wire in_wb   = act && state_q == ST_WB;
   wire busy    = in_exec || in_mem || in_wb;
   assign pc_en_out            = (in_exec && is_ctl) || (in_mem && is_store && mem_ready_in) || in_wb;
   assign branch_taken_out     = in_exec && is_ctl && (alu_branch_in || alu_jump_in);
   assign regfile_we_out       = in_wb;
   assign data_mem_re_out      = in_mem && is_load;
   assign data_mem_we_out      = in_mem && is_store;
   assign inst_mux_sel_out     = busy && dec.dest_rd;
   assign alu_mux_sel_out      = busy && dec.wb_mem;
   assign data_mem_mux_sel_out = busy && dec.b_imm;
   assign alu_func_out         = busy ? dec.alu_func : 6'h00;
   assign data_mem_size_out    = busy ? dec.size : 2'b00;
   assign halted_out           = act && state_q == ST_HALT;
   assign fault_out            = act ? fault_q : FAULT_NONE;
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: directed per-cycle stimulus with a queued scoreboard checked by a negedge monitor.
module tb_mips_control_fsm;
   logic       clk = 1'b0;
   logic       reset, run_in, alu_branch_in, alu_jump_in, mem_ready_in;
   logic [5:0] op, fn;
   logic       pc_en, im, rf_we, am, dm, re, we, bt, halted;
   logic [5:0] alu_func;
   logic [1:0] size, fault;
   int         checks = 0;
   int         failures = 0;
   typedef struct {
      string       nm;
      logic [18:0] v;
   } exp_t;
   exp_t exp_q[$];
   localparam logic [18:0] Z = '0;
   always #5 clk = ~clk;
   mips_control_fsm #(.MEM_TIMEOUT(4)) dut (
      .clock                (clk),
      .reset                (reset),
      .run_in               (run_in),
      .inst_mem_opcode_in   (op),
      .inst_mem_func_in     (fn),
      .alu_branch_in        (alu_branch_in),
      .alu_jump_in          (alu_jump_in),
      .mem_ready_in         (mem_ready_in),
      .pc_en_out            (pc_en),
      .inst_mux_sel_out     (im),
      .regfile_we_out       (rf_we),
      .alu_mux_sel_out      (am),
      .data_mem_mux_sel_out (dm),
      .alu_func_out         (alu_func),
      .data_mem_re_out      (re),
      .data_mem_we_out      (we),
      .data_mem_size_out    (size),
      .branch_taken_out     (bt),
      .halted_out           (halted),
      .fault_out            (fault)
   );
   wire [18:0] obs = {pc_en, im, rf_we, am, dm, alu_func, re, we, size, bt, halted, fault};
   function automatic logic [18:0] mk(input logic p, i, r, a, d, input logic [5:0] f, input logic rd, wr,
                                      input logic [1:0] s, input logic b, h, input logic [1:0] ft);
      return {p, i, r, a, d, f, rd, wr, s, b, h, ft};
   endfunction
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs !== e.v) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", e.nm, obs, e.v);
         end
      end
   end
   task automatic cyc(input string nm, input logic rs, run, input logic [5:0] o, f,
                      input logic br, jp, rdy, input logic [18:0] v);
      reset = rs; run_in = run; op = o; fn = f;
      alu_branch_in = br; alu_jump_in = jp; mem_ready_in = rdy;
      exp_q.push_back('{nm: nm, v: v});
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1; run_in = 1'b0; op = '0; fn = '0;
      alu_branch_in = 1'b0; alu_jump_in = 1'b0; mem_ready_in = 1'b0;
      @(posedge clk);
      #1;
      cyc("rst0", 1, 0, 6'h00, 6'h00, 0, 0, 0, Z);
      cyc("rst1", 1, 1, 6'h00, 6'h20, 1, 1, 1, Z);
      cyc("add_f", 0, 1, 6'h00, 6'h20, 0, 0, 0, Z);
      cyc("add_x", 0, 1, 6'h3F, 6'h00, 0, 0, 0, mk(0,1,0,0,0,6'h20,0,0,2'b10,0,0,2'b00));
      cyc("add_w", 0, 1, 6'h3F, 6'h00, 0, 0, 0, mk(1,1,1,0,0,6'h20,0,0,2'b10,0,0,2'b00));
      cyc("pause0", 0, 0, 6'h23, 6'h00, 1, 0, 1, Z);
      cyc("pause1", 0, 0, 6'h23, 6'h00, 1, 0, 1, Z);
      cyc("lw_f", 0, 1, 6'h23, 6'h00, 0, 0, 0, Z);
      cyc("lw_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,0,0,2'b10,0,0,2'b00));
      cyc("lw_m0", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,1,0,2'b10,0,0,2'b00));
      cyc("lw_m1", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,1,0,2'b10,0,0,2'b00));
      cyc("lw_m2", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(0,0,0,1,1,6'h21,1,0,2'b10,0,0,2'b00));
      cyc("lw_w", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,0,1,1,1,6'h21,0,0,2'b10,0,0,2'b00));
      cyc("sb_f", 0, 1, 6'h28, 6'h00, 0, 0, 1, Z);
      cyc("sb_x", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(0,0,0,0,1,6'h21,0,0,2'b00,0,0,2'b00));
      cyc("sb_m", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(1,0,0,0,1,6'h21,0,1,2'b00,0,0,2'b00));
      cyc("sw_f", 0, 1, 6'h2B, 6'h00, 0, 0, 0, Z);
      cyc("sw_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,0,1,6'h21,0,0,2'b10,0,0,2'b00));
      cyc("sw_m0", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,0,1,6'h21,0,1,2'b10,0,0,2'b00));
      cyc("sw_m1", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(1,0,0,0,1,6'h21,0,1,2'b10,0,0,2'b00));
      cyc("beq_f", 0, 1, 6'h04, 6'h00, 1, 0, 0, Z);
      cyc("beq_x", 0, 1, 6'h00, 6'h00, 1, 0, 0, mk(1,0,0,0,0,6'h3C,0,0,2'b10,1,0,2'b00));
      cyc("bne_f", 0, 1, 6'h05, 6'h00, 0, 0, 0, Z);
      cyc("bne_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,0,0,0,0,6'h3D,0,0,2'b10,0,0,2'b00));
      cyc("j_f", 0, 1, 6'h02, 6'h00, 0, 1, 0, Z);
      cyc("j_x", 0, 1, 6'h00, 6'h00, 0, 1, 0, mk(1,0,0,0,0,6'h3E,0,0,2'b10,1,0,2'b00));
      cyc("addi_f", 0, 1, 6'h08, 6'h00, 0, 0, 0, Z);
      cyc("addi_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,0,1,6'h20,0,0,2'b10,0,0,2'b00));
      cyc("addi_w", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,0,1,0,1,6'h20,0,0,2'b10,0,0,2'b00));
      cyc("lui_f", 0, 1, 6'h0F, 6'h00, 0, 0, 0, Z);
      cyc("lui_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,0,1,6'h3F,0,0,2'b10,0,0,2'b00));
      cyc("lui_w", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,0,1,0,1,6'h3F,0,0,2'b10,0,0,2'b00));
      cyc("rlw_f", 0, 1, 6'h23, 6'h00, 0, 0, 0, Z);
      cyc("rlw_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,0,0,2'b10,0,0,2'b00));
      cyc("rst_mem", 1, 1, 6'h00, 6'h00, 0, 0, 1, Z);
      cyc("sub_f", 0, 1, 6'h00, 6'h22, 0, 0, 0, Z);
      cyc("sub_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,1,0,0,0,6'h22,0,0,2'b10,0,0,2'b00));
      cyc("sub_w", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,1,1,0,0,6'h22,0,0,2'b10,0,0,2'b00));
      cyc("lh_f", 0, 1, 6'h21, 6'h00, 0, 0, 0, Z);
      cyc("lh_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,0,0,2'b01,0,0,2'b00));
      cyc("lh_m", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(0,0,0,1,1,6'h21,1,0,2'b01,0,0,2'b00));
      cyc("rst_wb", 1, 1, 6'h00, 6'h00, 0, 0, 1, Z);
      cyc("post_wb", 0, 0, 6'h00, 6'h00, 0, 0, 0, Z);
      cyc("andi_f", 0, 1, 6'h0C, 6'h00, 0, 0, 0, Z);
      cyc("andi_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,0,1,6'h24,0,0,2'b10,0,0,2'b00));
      cyc("andi_w", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(1,0,1,0,1,6'h24,0,0,2'b10,0,0,2'b00));
      cyc("to_f", 0, 1, 6'h23, 6'h00, 0, 0, 0, Z);
      cyc("to_x", 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,0,0,2'b10,0,0,2'b00));
      for (int i = 0; i < 4; i++)
         cyc($sformatf("to_m%0d", i), 0, 1, 6'h00, 6'h00, 0, 0, 0, mk(0,0,0,1,1,6'h21,1,0,2'b10,0,0,2'b00));
      cyc("to_h0", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(0,0,0,0,0,6'h00,0,0,2'b00,0,1,2'b10));
      cyc("to_h1", 0, 1, 6'h00, 6'h00, 1, 1, 1, mk(0,0,0,0,0,6'h00,0,0,2'b00,0,1,2'b10));
      cyc("rst2", 1, 0, 6'h00, 6'h00, 0, 0, 0, Z);
      cyc("il_f", 0, 1, 6'h3F, 6'h00, 0, 0, 0, Z);
      cyc("il_h0", 0, 1, 6'h00, 6'h00, 0, 0, 1, mk(0,0,0,0,0,6'h00,0,0,2'b00,0,1,2'b01));
      cyc("il_h1", 0, 1, 6'h00, 6'h00, 1, 0, 1, mk(0,0,0,0,0,6'h00,0,0,2'b00,0,1,2'b01));
      cyc("rst3", 1, 0, 6'h00, 6'h00, 0, 0, 0, Z);
      cyc("idle", 0, 0, 6'h00, 6'h00, 0, 0, 0, Z);
      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
